// File: rtl/mem_stall_tracker.sv
// Tracks outstanding memory requests per port and derives the pipeline advance enable.
// Also keeps a saturating stall counter, a stall watchdog and sticky protocol-error flags.
module mem_stall_tracker #(
  parameter int NPORT   = 2,
  parameter int MAX_OUT = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NPORT-1:0] req_i,
  input  logic [NPORT-1:0] resp_i,
  input  logic             clr_stats_i,
  output logic             move_o,
  output logic [NPORT-1:0] busy_o,
  output logic [31:0]      stall_cycles_o,
  output logic             err_overflow_o,
  output logic             err_spurious_o,
  output logic             err_timeout_o
);

  localparam int PW = $clog2(MAX_OUT + 1);
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(MAX_OUT);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT);

  logic [NPORT-1:0][PW-1:0] pend_q, pend_d;
  logic [NPORT-1:0]         resp_v, req_acc, ovf_hit, spur_hit, port_clear;
  logic [31:0]              stall_q, stall_d;
  logic [WW-1:0]            wd_q, wd_d;
  logic                     eo_q, eo_d, es_q, es_d, et_q, et_d;

  always_comb begin
    pend_d     = pend_q;
    resp_v     = '0;
    req_acc    = '0;
    ovf_hit    = '0;
    spur_hit   = '0;
    port_clear = '0;
    busy_o     = '0;
    for (int i = 0; i < NPORT; i++) begin
      resp_v[i]     = resp_i[i] && (pend_q[i] != '0);
      ovf_hit[i]    = req_i[i] && (pend_q[i] == PMAX) && !resp_v[i];
      req_acc[i]    = req_i[i] && !ovf_hit[i];
      spur_hit[i]   = resp_i[i] && (pend_q[i] == '0);
      pend_d[i]     = pend_q[i] + PW'(req_acc[i]) - PW'(resp_v[i]);
      // a port stops blocking in the same cycle its last response arrives
      port_clear[i] = (pend_q[i] == '0) || ((pend_q[i] == PW'(1)) && resp_i[i]);
      busy_o[i]     = !rst && (pend_q[i] != '0);
    end
  end

  assign move_o = !rst && (&port_clear);

  always_comb begin
    stall_d = stall_q;
    if (clr_stats_i)
      stall_d = '0;
    else if (!move_o && (stall_q != 32'hFFFF_FFFF))
      stall_d = stall_q + 32'd1;

    wd_d = wd_q;
    if (move_o)
      wd_d = '0;
    else if (wd_q != WMAX)
      wd_d = wd_q + WW'(1);

    eo_d = eo_q | (|ovf_hit);
    es_d = es_q | (|spur_hit);
    // flag appears the cycle after the watchdog has sat at its limit
    et_d = et_q | ((TIMEOUT != 0) && (wd_q == WMAX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q  <= '0;
      stall_q <= '0;
      wd_q    <= '0;
      eo_q    <= 1'b0;
      es_q    <= 1'b0;
      et_q    <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      stall_q <= stall_d;
      wd_q    <= wd_d;
      eo_q    <= eo_d;
      es_q    <= es_d;
      et_q    <= et_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign err_overflow_o = eo_q;
  assign err_spurious_o = es_q;
  assign err_timeout_o  = et_q;

endmodule

// File: tb/tb_mem_stall_tracker.sv
// Bench for mem_stall_tracker: three parameterisations driven by shared stimulus,
// each checked every cycle against a counting reference model.
module tb_mem_stall_tracker;

  localparam int NI = 3;
  localparam int MO [NI] = '{1, 3, 1};
  localparam int TO [NI] = '{1023, 8, 0};

  logic clk, rst, clr_r;
  logic [1:0] req_r, resp_r;

  logic [NI-1:0]        move_w, eo_w, es_w, et_w;
  logic [NI-1:0][1:0]   busy_w;
  logic [NI-1:0][31:0]  stall_w;

  mem_stall_tracker #(.NPORT(2), .MAX_OUT(1), .TIMEOUT(1023)) dut0 (
    .clk(clk), .rst(rst), .req_i(req_r), .resp_i(resp_r), .clr_stats_i(clr_r),
    .move_o(move_w[0]), .busy_o(busy_w[0]), .stall_cycles_o(stall_w[0]),
    .err_overflow_o(eo_w[0]), .err_spurious_o(es_w[0]), .err_timeout_o(et_w[0]));

  mem_stall_tracker #(.NPORT(2), .MAX_OUT(3), .TIMEOUT(8)) dut1 (
    .clk(clk), .rst(rst), .req_i(req_r), .resp_i(resp_r), .clr_stats_i(clr_r),
    .move_o(move_w[1]), .busy_o(busy_w[1]), .stall_cycles_o(stall_w[1]),
    .err_overflow_o(eo_w[1]), .err_spurious_o(es_w[1]), .err_timeout_o(et_w[1]));

  mem_stall_tracker #(.NPORT(2), .MAX_OUT(1), .TIMEOUT(0)) dut2 (
    .clk(clk), .rst(rst), .req_i(req_r), .resp_i(resp_r), .clr_stats_i(clr_r),
    .move_o(move_w[2]), .busy_o(busy_w[2]), .stall_cycles_o(stall_w[2]),
    .err_overflow_o(eo_w[2]), .err_spurious_o(es_w[2]), .err_timeout_o(et_w[2]));

  // reference model state
  int          pend_m [NI][2];
  logic [31:0] stall_m [NI];
  int          wd_m [NI];
  bit          eo_m [NI], es_m [NI], et_m [NI];

  int n_cmp = 0;
  int n_fail = 0;
  logic [NI-1:0] mv_seen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_move(input int k);
    bit ok = !rst;
    for (int p = 0; p < 2; p++)
      if (!(pend_m[k][p] == 0 || (pend_m[k][p] == 1 && resp_r[p]))) ok = 0;
    return ok;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      pend_m[k][0] = 0; pend_m[k][1] = 0;
      stall_m[k] = 0; wd_m[k] = 0;
      eo_m[k] = 0; es_m[k] = 0; et_m[k] = 0;
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < NI; k++) begin
      if (rst) begin
        pend_m[k][0] = 0; pend_m[k][1] = 0;
        stall_m[k] = 0; wd_m[k] = 0;
        eo_m[k] = 0; es_m[k] = 0; et_m[k] = 0;
      end else begin
        bit mv = model_move(k);
        for (int p = 0; p < 2; p++) begin
          bit v = resp_r[p] && pend_m[k][p] > 0;
          if (resp_r[p] && pend_m[k][p] == 0) es_m[k] = 1;
          if (req_r[p] && pend_m[k][p] == MO[k] && !v) eo_m[k] = 1;
          else if (req_r[p]) pend_m[k][p]++;
          if (v) pend_m[k][p]--;
        end
        if (clr_r) stall_m[k] = 0;
        else if (!mv && stall_m[k] != 32'hFFFF_FFFF) stall_m[k]++;
        if (TO[k] != 0 && wd_m[k] == TO[k]) et_m[k] = 1;
        if (mv) wd_m[k] = 0;
        else if (wd_m[k] < TO[k]) wd_m[k]++;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("move[%0d]", k), 32'(move_w[k]), 32'(model_move(k)));
      for (int p = 0; p < 2; p++)
        chk($sformatf("busy[%0d][%0d]", k, p), 32'(busy_w[k][p]),
            32'(!rst && pend_m[k][p] > 0));
      chk($sformatf("stall[%0d]", k), stall_w[k], stall_m[k]);
      chk($sformatf("err_ovf[%0d]", k), 32'(eo_w[k]), 32'(eo_m[k]));
      chk($sformatf("err_spur[%0d]", k), 32'(es_w[k]), 32'(es_m[k]));
      chk($sformatf("err_to[%0d]", k), 32'(et_w[k]), 32'(et_m[k]));
    end
  endtask

  // inputs applied just after a rising edge, outputs checked mid-cycle
  task automatic step(input logic [1:0] rq, input logic [1:0] rs,
                      input logic cl = 1'b0, input logic r = 1'b0);
    req_r = rq; resp_r = rs; clr_r = cl; rst = r;
    #3;
    mv_seen = move_w;
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    rst = 1'b1; req_r = 2'b00; resp_r = 2'b00; clr_r = 1'b0;
    model_reset();
    @(posedge clk); #1;
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b11, 2'b11, 1'b1, 1'b1);
    step(2'b00, 2'b00);

    // both ports request together, answered at different times
    step(2'b11, 2'b00); chk("seq_move0", 32'(mv_seen[0]), 32'd1);
    step(2'b00, 2'b00); chk("seq_move1", 32'(mv_seen[0]), 32'd0);
    step(2'b00, 2'b01); chk("seq_move2", 32'(mv_seen[0]), 32'd0);
    step(2'b00, 2'b00); chk("seq_move3", 32'(mv_seen[0]), 32'd0);
    step(2'b00, 2'b10); chk("seq_move4", 32'(mv_seen[0]), 32'd1);
    chk("seq_stall", stall_w[0], 32'd3);

    // overflow on the single-outstanding instance
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    chk("ovf_flag", 32'(eo_w[0]), 32'd1);
    step(2'b00, 2'b01); chk("ovf_release", 32'(mv_seen[0]), 32'd1);
    step(2'b00, 2'b01);

    // stray response on an idle port
    step(2'b00, 2'b10); chk("spur_move", 32'(mv_seen[0]), 32'd1);
    chk("spur_flag", 32'(es_w[0]), 32'd1);
    chk("spur_busy", 32'(busy_w[0]), 32'd0);

    // three back-to-back requests with depth 3
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b01, 2'b00);
    step(2'b00, 2'b01); chk("deep_r1", 32'(mv_seen[1]), 32'd0);
    step(2'b00, 2'b01); chk("deep_r2", 32'(mv_seen[1]), 32'd0);
    step(2'b00, 2'b01); chk("deep_r3", 32'(mv_seen[1]), 32'd1);
    chk("deep_busy", 32'(busy_w[1][0]), 32'd0);

    // reset abandons an outstanding request
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b00);
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b00, 2'b00); chk("rst_move", 32'(mv_seen[0]), 32'd1);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    step(2'b00, 2'b01);
    chk("rst_spur", 32'(es_w[0]), 32'd1);

    // watchdog: a request that is never answered
    step(2'b00, 2'b00, 1'b0, 1'b1);
    step(2'b01, 2'b00);
    for (int i = 0; i < 8; i++) step(2'b00, 2'b00);
    chk("wd_not_yet", 32'(et_w[1]), 32'd0);
    step(2'b00, 2'b00);
    chk("wd_fired", 32'(et_w[1]), 32'd1);
    for (int i = 0; i < 4; i++) step(2'b00, 2'b00);
    chk("wd_disabled", 32'(et_w[2]), 32'd0);
    step(2'b00, 2'b00, 1'b1);
    chk("clr_stall", stall_w[1], 32'd0);
    chk("clr_keeps_err", 32'(et_w[1]), 32'd1);
    step(2'b00, 2'b01);

    // randomized traffic
    step(2'b00, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] rq, rs;
      rq = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      rs = 2'($urandom_range(0, 3));
      step(rq, rs, ($urandom_range(0, 49) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stall_tracker.md
MEM_STALL_TRACKER -- requirements
Module: mem_stall_tracker

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of independent memory request/response ports.
REQ-002 SHALL have parameter MAX_OUT, default 1, maximum outstanding requests per port (range 1..15).
REQ-003 SHALL have parameter TIMEOUT, default 1023, consecutive stall cycles before watchdog error; 0 disables the watchdog.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port req  input  NPORT  per-port request issued this cycle (one request per port per cycle max).
REQ-007 SHALL have port resp  input  NPORT  per-port response returned this cycle.
REQ-008 SHALL have port clr_stats  input  1  clears the stall cycle counter.
REQ-009 SHALL have port move  output  1  pipeline advance enable.
REQ-010 SHALL have port busy  output  NPORT  bit i high when port i has an outstanding request.
REQ-011 SHALL have port stall_cycles  output  32  saturating count of cycles with move low.
REQ-012 SHALL have port err_overflow  output  1  sticky: request issued while port already at MAX_OUT.
REQ-013 SHALL have port err_spurious  output  1  sticky: response received while port had nothing outstanding.
REQ-014 SHALL have port err_timeout  output  1  sticky: watchdog expired.

Function
REQ-015 SHALL keep per-port pending counter pend[i], width clog2(MAX_OUT+1).
REQ-016 SHALL compute pend_next[i] = pend[i] + req[i] - resp_v[i], where resp_v[i] = resp[i] AND pend[i]!=0.
REQ-017 SHALL, on req[i] with pend[i]==MAX_OUT and no resp_v[i], drop the request (pend unchanged) and set err_overflow.
REQ-018 SHALL, on resp[i] with pend[i]==0, ignore the response and set err_spurious; a same-cycle req[i] still increments pend[i].
REQ-019 SHALL drive move combinationally high iff not rst and, for every port i, pend[i]==0 or (pend[i]==1 and resp[i]).
REQ-020 SHALL not let requests issued in the current cycle hold move low in that cycle; they block from the next cycle.
REQ-021 SHALL, with MAX_OUT>1, hold move low until every outstanding request on every port is answered.
REQ-022 SHALL drive busy[i] = (pend[i]!=0), registered-state derived, no combinational path from req/resp.
REQ-023 SHALL increment stall_cycles each non-reset cycle with move low, saturating at 32'hFFFF_FFFF; clr_stats takes priority and loads 0.
REQ-024 SHALL keep watchdog counter wd counting consecutive move-low cycles, cleared to 0 on any move-high cycle.
REQ-025 SHALL set err_timeout in the cycle after wd reaches TIMEOUT (TIMEOUT!=0), wd then holds; never set when TIMEOUT==0.
REQ-026 SHALL handle simultaneous responses on all ports in one cycle, each decrementing its own counter.
REQ-027 SHALL with NPORT=2, MAX_OUT=1 reproduce the single-outstanding imem/dmem stall behaviour cycle-exactly.

Reset
REQ-028 SHALL on rst clear pend, wd, stall_cycles and all err_* flags; move=0 and busy=0 while rst high.
REQ-029 SHALL treat rst asserted mid-transaction as abandoning all outstanding requests; responses after reset for those set err_spurious.
REQ-030 SHALL clear err_* flags only by rst (clr_stats does not affect them).

Verification
REQ-031 SHALL cover: defaults, req=2'b11 cycle0, resp[0] cycle2, resp[1] cycle4 -> move 1,0,0,0,1; stall_cycles=3.
REQ-032 SHALL cover: MAX_OUT=3, three req[0] back-to-back, one resp per cycle after -> move high only on third resp, busy[0] low next cycle.
REQ-033 SHALL cover: defaults, req[0] twice without resp -> err_overflow=1, pend[0]=1, single resp releases move.
REQ-034 SHALL cover: resp[1] with nothing pending -> err_spurious=1, move unaffected, busy unchanged.
REQ-035 SHALL cover: TIMEOUT=8, req[0] never answered -> err_timeout=1 after 8 stall cycles; TIMEOUT=0 -> never set.
REQ-036 SHALL cover: rst pulsed with pend[0]=1 -> all outputs cleared next cycle, move=1 once rst low.
